// File: rtl/regfile_arbiter.sv
// Three-requester round-robin arbiter in front of a 2-read/1-write register file.
// Each transaction walks IDLE -> ISSUE -> DONE; the rf_* port is driven only in ISSUE.
module regfile_arbiter #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      req,
  input  logic [2:0]      req_wr,
  input  logic [3*AW-1:0] req_reg1,
  input  logic [3*AW-1:0] req_reg2,
  input  logic [3*DW-1:0] req_wdata,
  output logic [2:0]      ack,
  output logic [DW-1:0]   rdata1,
  output logic [DW-1:0]   rdata2,
  output logic            busy,
  output logic            rf_read_enable,
  output logic            rf_write_enable,
  output logic [AW-1:0]   rf_reg1,
  output logic [AW-1:0]   rf_reg2,
  output logic [DW-1:0]   rf_in_data,
  input  logic [DW-1:0]   rf_out_data1,
  input  logic [DW-1:0]   rf_out_data2,
  output logic [1:0]      dbg_state
);

  // Handshake: a requester holds req high until it sees its one-cycle ack pulse,
  // then must drop req; req still high in the following IDLE cycle is a new request.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state, next_state;
  logic [1:0]      last_grant;
  logic [1:0]      win;
  logic            wr_q;
  logic [1:0]      grant;
  logic [1:0]      start;
  logic [1:0]      cand;
  logic            found;
  logic            sel_wr;
  logic [AW-1:0]   sel_reg1;
  logic [AW-1:0]   sel_reg2;
  logic [DW-1:0]   sel_wdata;

  // Round-robin search beginning just after the previous winner.
  always_comb begin
    grant = 2'd0;
    found = 1'b0;
    start = (last_grant == 2'd2) ? 2'd0 : last_grant + 2'd1;
    cand  = start;
    for (int k = 0; k < 3; k++) begin
      if (!found && req[cand]) begin
        grant = cand;
        found = 1'b1;
      end
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
    end
  end

  always_comb begin
    sel_wr    = 1'b0;
    sel_reg1  = '0;
    sel_reg2  = '0;
    sel_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      if (grant == 2'(i)) begin
        sel_wr    = req_wr[i];
        sel_reg1  = req_reg1[i*AW +: AW];
        sel_reg2  = req_reg2[i*AW +: AW];
        sel_wdata = req_wdata[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (found) next_state = ISSUE;
      ISSUE:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The rf_* registers double as the latched transaction, so later input
  // changes cannot reach the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant      <= 2'd2;
      win             <= 2'd0;
      wr_q            <= 1'b0;
      ack             <= 3'b000;
      rdata1          <= '0;
      rdata2          <= '0;
      rf_read_enable  <= 1'b0;
      rf_write_enable <= 1'b0;
      rf_reg1         <= '0;
      rf_reg2         <= '0;
      rf_in_data      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            win             <= grant;
            wr_q            <= sel_wr;
            rf_write_enable <= sel_wr;
            rf_read_enable  <= !sel_wr;
            rf_reg1         <= sel_reg1;
            rf_reg2         <= sel_wr ? '0 : sel_reg2;
            rf_in_data      <= sel_wr ? sel_wdata : '0;
          end
        end
        ISSUE: begin
          rf_read_enable  <= 1'b0;
          rf_write_enable <= 1'b0;
          rf_reg1         <= '0;
          rf_reg2         <= '0;
          rf_in_data      <= '0;
          if (!wr_q) begin
            rdata1 <= rf_out_data1;
            rdata2 <= rf_out_data2;
          end
          ack <= 3'b001 << win;
        end
        DONE: begin
          ack        <= 3'b000;
          last_grant <= win;
        end
        default: ack <= 3'b000;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 Parameter DW, default 16, register data width.
REQ-002 Parameter AW, default 4, register index width (2^AW registers).
REQ-003 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 Port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 Port req, input, 3, per-requester request; held high until ack.
REQ-006 Port req_wr, input, 3, per-requester op: 1 write, 0 read.
REQ-007 Port req_reg1, input, 3*AW, packed per requester; write target or read port-1 index.
REQ-008 Port req_reg2, input, 3*AW, packed per requester; read port-2 index (ignored on write).
REQ-009 Port req_wdata, input, 3*DW, packed per requester; write data.
REQ-010 Port ack, output, 3, one-hot completion pulse, one cycle.
REQ-011 Port rdata1 / rdata2, output, DW each, read results; valid only while ack is high for a read.
REQ-012 Port busy, output, 1, high whenever FSM is not IDLE.
REQ-013 Ports rf_read_enable, rf_write_enable, output, 1 each, register-file port enables.
REQ-014 Ports rf_reg1, rf_reg2, output, AW each; rf_in_data, output, DW; register-file address and data.
REQ-015 Ports rf_out_data1, rf_out_data2, input, DW each, register-file read data.

Function
REQ-016 FSM SHALL have three states: IDLE, ISSUE, DONE; transitions IDLE->ISSUE on any req bit high, ISSUE->DONE unconditionally, DONE->IDLE unconditionally.
REQ-017 In IDLE, winner SHALL be chosen round-robin: search order starts at (last_grant+1) mod 3 and proceeds upward mod 3; first req bit high wins.
REQ-018 On IDLE->ISSUE, winner index, op, reg1, reg2 and wdata SHALL be latched; later changes on requester inputs SHALL not affect the transaction.
REQ-019 All rf_* outputs SHALL be registered and driven only during ISSUE: write -> rf_write_enable=1, rf_read_enable=0, rf_reg1=latched reg1, rf_in_data=latched wdata; read -> rf_read_enable=1, rf_write_enable=0, rf_reg1/rf_reg2=latched indices.
REQ-020 Outside ISSUE, rf_read_enable and rf_write_enable SHALL be 0, rf_reg1/rf_reg2/rf_in_data SHALL be 0.
REQ-021 For a read, rf_out_data1/2 SHALL be sampled at the rising edge ending ISSUE into rdata1/rdata2.
REQ-022 In DONE, ack[winner] SHALL be 1 and all other ack bits 0; last_grant SHALL update to winner on DONE->IDLE.
REQ-023 rdata1/rdata2 SHALL hold their last captured value until the next read capture; a write transaction SHALL not modify them.
REQ-024 Latency: request seen in IDLE at cycle N -> ISSUE cycle N+1 -> ack at cycle N+2; throughput one transaction per 3 cycles.
REQ-025 A requester whose req is still high in the IDLE cycle after its ack SHALL be treated as a new request (requester must drop req after ack).
REQ-026 Simultaneous requests SHALL be serviced one at a time; no requester SHALL wait more than two other transactions (starvation bound).
REQ-027 req bits going low while not granted SHALL simply withdraw; req of the active winner dropping mid-transaction SHALL not abort it.

Reset
REQ-028 While rst_n=0: state=IDLE, last_grant=2 (requester 0 highest priority first), ack=0, busy=0, rdata1=rdata2=0, all rf_* outputs 0.
REQ-029 Reset asserted mid-transaction SHALL abort it immediately with no ack; an in-flight write may or may not complete at the register file only if the clock edge preceded reset.
REQ-030 First request after rst_n deassertion SHALL be evaluated in the first IDLE cycle.

Verification
REQ-031 Single write: req=001, req_wr=001, reg1=5, wdata=0xBEEF -> ISSUE cycle shows rf_write_enable=1, rf_reg1=5, rf_in_data=0xBEEF; ack=001 two cycles after request.
REQ-032 Read-back: after REQ-031, requester 1 read reg1=5, reg2=0 with reg0 holding 0x0000 -> ack=010, rdata1=0xBEEF, rdata2=0x0000.
REQ-033 Contention: req=111 held, each dropped one cycle after its ack -> grant order 0,1,2, acks at cycles 2,5,8 after first request.
REQ-034 Rotation: after grant to 1, req=101 -> requester 2 granted before requester 0.
REQ-035 Input change: winner's wdata changed from 0x1111 to 0x2222 during ISSUE -> rf_in_data remains 0x1111.
REQ-036 Reset mid-ISSUE: rst_n pulsed low -> ack never asserts, rf enables and busy go to 0 immediately, next request gives priority to requester 0.
